// File: rtl/y86_pkg.sv
// Shared Y86-64 encodings: instruction codes, status codes, the "no register" ID
// and the control fields loaded into the E register on a bubble.
package y86_pkg;

  localparam logic [3:0] I_HALT   = 4'h0;
  localparam logic [3:0] I_NOP    = 4'h1;
  localparam logic [3:0] I_RRMOVQ = 4'h2;
  localparam logic [3:0] I_IRMOVQ = 4'h3;
  localparam logic [3:0] I_RMMOVQ = 4'h4;
  localparam logic [3:0] I_MRMOVQ = 4'h5;
  localparam logic [3:0] I_OPQ    = 4'h6;
  localparam logic [3:0] I_JXX    = 4'h7;
  localparam logic [3:0] I_CALL   = 4'h8;
  localparam logic [3:0] I_RET    = 4'h9;
  localparam logic [3:0] I_PUSHQ  = 4'hA;
  localparam logic [3:0] I_POPQ   = 4'hB;

  localparam logic [3:0] S_AOK = 4'h1;
  localparam logic [3:0] S_HLT = 4'h2;
  localparam logic [3:0] S_ADR = 4'h3;
  localparam logic [3:0] S_INS = 4'h4;

  // "No register" for the standard 4-bit register-ID encoding.
  localparam logic [3:0] RNONE = 4'hF;

  typedef struct packed {
    logic [3:0] stat;
    logic [3:0] icode;
    logic [3:0] ifun;
  } e_ctrl_t;

  localparam e_ctrl_t BUBBLE_CTRL = '{stat: S_AOK, icode: I_NOP, ifun: 4'h0};

  function automatic logic is_load(input logic [3:0] icode);
    return (icode == I_MRMOVQ) || (icode == I_POPQ);
  endfunction

endpackage

// File: rtl/y86_regfile.sv
// Y86-64 register file: two combinational read ports, two synchronous write ports
// (M port wins on a same-ID collision), synchronous clear.
module y86_regfile #(
  parameter int XLEN  = 64,
  parameter int RID_W = 4,
  parameter int NREG  = 15
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [RID_W-1:0] rd_a_id,
  input  logic [RID_W-1:0] rd_b_id,
  output logic [XLEN-1:0]  rd_a_val,
  output logic [XLEN-1:0]  rd_b_val,
  input  logic [RID_W-1:0] wr_e_id,
  input  logic [RID_W-1:0] wr_m_id,
  input  logic [XLEN-1:0]  wr_e_val,
  input  logic [XLEN-1:0]  wr_m_val
);

  logic [XLEN-1:0] rf [NREG];

  for (genvar gi = 0; gi < NREG; gi++) begin : g_reg
    logic [XLEN-1:0] q_reg;

    always_ff @(posedge clk) begin
      if (rst) begin
        q_reg <= '0;
      end else if (wr_m_id == RID_W'(gi)) begin
        q_reg <= wr_m_val;
      end else if (wr_e_id == RID_W'(gi)) begin
        q_reg <= wr_e_val;
      end
    end

    assign rf[gi] = q_reg;
  end

  // IDs at or above NREG (including RNONE) read as zero.
  always_comb begin
    rd_a_val = '0;
    rd_b_val = '0;
    if (int'(rd_a_id) < NREG) rd_a_val = rf[rd_a_id];
    if (int'(rd_b_id) < NREG) rd_b_val = rf[rd_b_id];
  end

endmodule

// File: rtl/decode_fwd_stage.sv
// Y86-64 decode stage: source/destination decode, register read with full forwarding,
// load-use stall detection and the D->E pipeline register.
module decode_fwd_stage
  import y86_pkg::*;
#(
  parameter int XLEN   = 64,
  parameter int RID_W  = 4,
  parameter int NREG   = 15,
  parameter int RSP_ID = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       D_stat,
  input  logic [3:0]       D_icode,
  input  logic [3:0]       D_ifun,
  input  logic [RID_W-1:0] D_rA,
  input  logic [RID_W-1:0] D_rB,
  input  logic [XLEN-1:0]  D_valC,
  input  logic [XLEN-1:0]  D_valP,
  input  logic [RID_W-1:0] e_dstE,
  input  logic [XLEN-1:0]  e_valE,
  input  logic [RID_W-1:0] M_dstE,
  input  logic [RID_W-1:0] M_dstM,
  input  logic [XLEN-1:0]  M_valE,
  input  logic [XLEN-1:0]  m_valM,
  input  logic [RID_W-1:0] W_dstE,
  input  logic [RID_W-1:0] W_dstM,
  input  logic [XLEN-1:0]  W_valE,
  input  logic [XLEN-1:0]  W_valM,
  input  logic             E_bubble_req,
  output logic             d_stall,
  output logic [3:0]       E_stat,
  output logic [3:0]       E_icode,
  output logic [3:0]       E_ifun,
  output logic [XLEN-1:0]  E_valC,
  output logic [XLEN-1:0]  E_valA,
  output logic [XLEN-1:0]  E_valB,
  output logic [RID_W-1:0] E_dstE,
  output logic [RID_W-1:0] E_dstM,
  output logic [RID_W-1:0] E_srcA,
  output logic [RID_W-1:0] E_srcB
);

  localparam logic [RID_W-1:0] RNONE_ID = {RID_W{1'b1}};
  localparam logic [RID_W-1:0] RSP      = RID_W'(RSP_ID);

  logic [RID_W-1:0] d_srcA, d_srcB, d_dstE, d_dstM;
  logic [XLEN-1:0]  rf_a, rf_b, d_valA, d_valB;

  always_comb begin
    d_srcA = RNONE_ID;
    d_srcB = RNONE_ID;
    d_dstE = RNONE_ID;
    d_dstM = RNONE_ID;
    case (D_icode)
      I_RRMOVQ: begin d_srcA = D_rA; d_dstE = D_rB; end
      I_IRMOVQ: begin d_dstE = D_rB; end
      I_RMMOVQ: begin d_srcA = D_rA; d_srcB = D_rB; end
      I_MRMOVQ: begin d_srcB = D_rB; d_dstM = D_rA; end
      I_OPQ:    begin d_srcA = D_rA; d_srcB = D_rB; d_dstE = D_rB; end
      I_CALL:   begin d_srcB = RSP;  d_dstE = RSP; end
      I_RET:    begin d_srcA = RSP;  d_srcB = RSP;  d_dstE = RSP; end
      I_PUSHQ:  begin d_srcA = D_rA; d_srcB = RSP;  d_dstE = RSP; end
      I_POPQ:   begin d_srcA = RSP;  d_srcB = RSP;  d_dstE = RSP; d_dstM = D_rA; end
      default:  ;
    endcase
  end

  y86_regfile #(
    .XLEN  (XLEN),
    .RID_W (RID_W),
    .NREG  (NREG)
  ) u_regfile (
    .clk      (clk),
    .rst      (rst),
    .rd_a_id  (d_srcA),
    .rd_b_id  (d_srcB),
    .rd_a_val (rf_a),
    .rd_b_val (rf_b),
    .wr_e_id  (W_dstE),
    .wr_m_id  (W_dstM),
    .wr_e_val (W_valE),
    .wr_m_val (W_valM)
  );

  // Youngest producer wins; RNONE sources never forward.
  function automatic logic [XLEN-1:0] fwd_sel(input logic [RID_W-1:0] src,
                                              input logic [XLEN-1:0]  rf_val);
    if (src == RNONE_ID)    return rf_val;
    else if (src == e_dstE) return e_valE;
    else if (src == M_dstM) return m_valM;
    else if (src == M_dstE) return M_valE;
    else if (src == W_dstM) return W_valM;
    else if (src == W_dstE) return W_valE;
    else                    return rf_val;
  endfunction

  always_comb begin
    d_valA = fwd_sel(d_srcA, rf_a);
    d_valB = fwd_sel(d_srcB, rf_b);
    if (D_icode == I_CALL || D_icode == I_JXX) d_valA = D_valP;
  end

  assign d_stall = is_load(E_icode) && (E_dstM != RNONE_ID) &&
                   ((E_dstM == d_srcA) || (E_dstM == d_srcB));

  always_ff @(posedge clk) begin
    if (rst || d_stall || E_bubble_req) begin
      E_stat  <= BUBBLE_CTRL.stat;
      E_icode <= BUBBLE_CTRL.icode;
      E_ifun  <= BUBBLE_CTRL.ifun;
      E_valC  <= '0;
      E_valA  <= '0;
      E_valB  <= '0;
      E_dstE  <= RNONE_ID;
      E_dstM  <= RNONE_ID;
      E_srcA  <= RNONE_ID;
      E_srcB  <= RNONE_ID;
    end else begin
      E_stat  <= D_stat;
      E_icode <= D_icode;
      E_ifun  <= D_ifun;
      E_valC  <= D_valC;
      E_valA  <= d_valA;
      E_valB  <= d_valB;
      E_dstE  <= d_dstE;
      E_dstM  <= d_dstM;
      E_srcA  <= d_srcA;
      E_srcB  <= d_srcB;
    end
  end

endmodule

// File: tb/tb_decode_fwd_stage.sv
// Table-driven bench for decode_fwd_stage: each row drives one cycle of D/forwarding
// inputs and lists the hand-computed stall and E-register contents that follow.
module tb_decode_fwd_stage;

  localparam logic [3:0] N = 4'hF;
  localparam int NV = 24;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  D_stat, D_icode, D_ifun, D_rA, D_rB;
  logic [63:0] D_valC, D_valP;
  logic [3:0]  e_dstE, M_dstE, M_dstM, W_dstE, W_dstM;
  logic [63:0] e_valE, M_valE, m_valM, W_valE, W_valM;
  logic        E_bubble_req;
  logic        d_stall;
  logic [3:0]  E_stat, E_icode, E_ifun, E_dstE, E_dstM, E_srcA, E_srcB;
  logic [63:0] E_valC, E_valA, E_valB;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  decode_fwd_stage dut (
    .clk(clk), .rst(rst),
    .D_stat(D_stat), .D_icode(D_icode), .D_ifun(D_ifun), .D_rA(D_rA), .D_rB(D_rB),
    .D_valC(D_valC), .D_valP(D_valP),
    .e_dstE(e_dstE), .e_valE(e_valE),
    .M_dstE(M_dstE), .M_dstM(M_dstM), .M_valE(M_valE), .m_valM(m_valM),
    .W_dstE(W_dstE), .W_dstM(W_dstM), .W_valE(W_valE), .W_valM(W_valM),
    .E_bubble_req(E_bubble_req), .d_stall(d_stall),
    .E_stat(E_stat), .E_icode(E_icode), .E_ifun(E_ifun),
    .E_valC(E_valC), .E_valA(E_valA), .E_valB(E_valB),
    .E_dstE(E_dstE), .E_dstM(E_dstM), .E_srcA(E_srcA), .E_srcB(E_srcB)
  );

  typedef struct {
    logic        rst, breq;
    logic [3:0]  stat, icode, ifun, ra, rb;
    logic [63:0] valp;
    logic [3:0]  e_dste;
    logic [63:0] e_vale;
    logic [3:0]  m_dste, m_dstm;
    logic [63:0] m_vale, m_valm;
    logic [3:0]  w_dste, w_dstm;
    logic [63:0] w_vale, w_valm;
    logic        x_stall, x_bubble;
    logic [63:0] x_vala, x_valb;
    logic [3:0]  x_dste, x_dstm, x_srca, x_srcb;
    string       name;
  } vec_t;

  vec_t vecs [NV];

  task automatic chk(input string name, input string field,
                     input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s.%s: got %0h expected %0h", name, field, act, exp);
    end
  endtask

  initial begin
    // rst breq stat icode ifun rA rB valP | e_dstE e_valE | M_dstE M_dstM M_valE m_valM | W_dstE W_dstM W_valE W_valM | stall bubble valA valB dstE dstM srcA srcB
    vecs[0]  = '{1,0,1,6,0,0,3,0,       N,0, N,N,0,0,           N,N,0,0,             0,1,0,0,N,N,N,N, "reset"};
    vecs[1]  = '{0,0,1,6,0,0,1,0,       N,0, N,N,0,0,           N,N,0,0,             0,0,0,0,1,N,0,1, "opq_after_reset"};
    vecs[2]  = '{0,0,1,3,0,N,0,0,       N,0, N,N,0,0,           N,N,0,0,             0,0,0,0,0,N,N,N, "irmovq"};
    vecs[3]  = '{0,0,1,6,0,0,3,0,       0,5, N,N,0,0,           N,N,0,0,             0,0,5,0,3,N,0,3, "fwd_e"};
    vecs[4]  = '{0,0,1,6,0,2,1,0,       2,7, N,2,0,9,           N,N,0,0,             0,0,7,0,1,N,2,1, "e_over_mm"};
    vecs[5]  = '{0,0,1,6,0,2,1,0,       N,7, N,2,0,9,           N,N,0,0,             0,0,9,0,1,N,2,1, "fwd_mm"};
    vecs[6]  = '{0,0,1,6,0,2,1,0,       N,0, N,N,0,0,           N,2,0,3,             0,0,3,0,1,N,2,1, "fwd_wm"};
    vecs[7]  = '{0,0,1,1,0,0,0,0,       N,0, N,N,0,0,           2,2,1,2,             0,0,0,0,N,N,N,N, "nop_dual_write"};
    vecs[8]  = '{0,0,1,6,0,2,2,0,       N,0, N,N,0,0,           N,N,0,0,             0,0,2,2,2,N,2,2, "rf_m_wins"};
    vecs[9]  = '{0,0,1,8,0,N,N,64'h40,  N,0, 4,N,64'h100,0,     N,N,0,0,             0,0,64'h40,64'h100,4,N,N,4, "call"};
    vecs[10] = '{0,0,1,7,1,N,N,64'h88,  N,0, N,N,0,0,           N,N,0,0,             0,0,64'h88,0,N,N,N,N, "jxx"};
    vecs[11] = '{0,0,1,5,0,3,1,0,       N,0, N,N,0,0,           1,N,64'h55,0,        0,0,0,64'h55,N,3,N,1, "mrmovq"};
    vecs[12] = '{0,0,1,6,0,3,1,0,       N,0, N,N,0,0,           N,N,0,0,             1,1,0,0,N,N,N,N, "load_use_stall"};
    vecs[13] = '{0,0,1,6,0,3,1,0,       N,0, N,3,0,64'h1234,    N,N,0,0,             0,0,64'h1234,64'h55,1,N,3,1, "after_stall_fwd"};
    vecs[14] = '{0,0,1,4'hB,0,0,N,0,    N,0, N,N,0,0,           4,4,64'h300,64'h200, 0,0,64'h200,64'h200,4,0,4,4, "popq_w_prio"};
    vecs[15] = '{0,1,1,4,0,N,0,0,       N,0, N,N,0,0,           N,N,0,0,             1,1,0,0,N,N,N,N, "stall_and_bubble"};
    vecs[16] = '{0,0,1,4'hA,0,1,N,0,    N,0, N,N,0,0,           N,N,0,0,             0,0,64'h55,64'h200,4,N,1,4, "pushq"};
    vecs[17] = '{0,1,1,6,0,0,1,0,       N,0, N,N,0,0,           N,N,0,0,             0,1,0,0,N,N,N,N, "bubble_req"};
    vecs[18] = '{0,0,2,9,0,N,N,0,       N,0, N,N,0,0,           N,N,0,0,             0,0,64'h200,64'h200,4,N,4,4, "ret_stat"};
    vecs[19] = '{0,0,1,2,3,1,2,0,       N,0, N,N,0,0,           N,N,0,0,             0,0,64'h55,0,2,N,1,N, "cmov"};
    vecs[20] = '{1,0,1,6,0,1,2,0,       N,0, N,N,0,0,           N,N,0,0,             0,1,0,0,N,N,N,N, "reset_mid"};
    vecs[21] = '{0,0,1,6,0,1,4,0,       N,0, N,N,0,0,           N,N,0,0,             0,0,0,0,4,N,1,4, "rf_cleared"};
    vecs[22] = '{0,0,1,4'hC,0,1,2,0,    N,0, N,N,0,0,           N,N,0,0,             0,0,0,0,N,N,N,N, "bad_icode"};
    vecs[23] = '{0,0,1,6,0,1,2,0,       N,0, 2,N,64'h99,0,      1,2,64'h77,64'hAA,   0,0,64'h77,64'h99,2,N,1,2, "fwd_me_we"};

    for (int i = 0; i < NV; i++) begin
      rst          = vecs[i].rst;
      E_bubble_req = vecs[i].breq;
      D_stat       = vecs[i].stat;
      D_icode      = vecs[i].icode;
      D_ifun       = vecs[i].ifun;
      D_rA         = vecs[i].ra;
      D_rB         = vecs[i].rb;
      D_valC       = 64'hC000 + 64'(i);
      D_valP       = vecs[i].valp;
      e_dstE       = vecs[i].e_dste;
      e_valE       = vecs[i].e_vale;
      M_dstE       = vecs[i].m_dste;
      M_dstM       = vecs[i].m_dstm;
      M_valE       = vecs[i].m_vale;
      m_valM       = vecs[i].m_valm;
      W_dstE       = vecs[i].w_dste;
      W_dstM       = vecs[i].w_dstm;
      W_valE       = vecs[i].w_vale;
      W_valM       = vecs[i].w_valm;
      #1;
      // E holds whatever was loaded last cycle, so the stall check precedes the edge.
      if (!vecs[i].rst) chk(vecs[i].name, "d_stall", 64'(d_stall), 64'(vecs[i].x_stall));
      @(posedge clk);
      #1;
      if (vecs[i].x_bubble) begin
        chk(vecs[i].name, "E_stat",  64'(E_stat),  64'h1);
        chk(vecs[i].name, "E_icode", 64'(E_icode), 64'h1);
        chk(vecs[i].name, "E_ifun",  64'(E_ifun),  64'h0);
        chk(vecs[i].name, "E_valC",  E_valC,       64'h0);
      end else begin
        chk(vecs[i].name, "E_stat",  64'(E_stat),  64'(vecs[i].stat));
        chk(vecs[i].name, "E_icode", 64'(E_icode), 64'(vecs[i].icode));
        chk(vecs[i].name, "E_ifun",  64'(E_ifun),  64'(vecs[i].ifun));
        chk(vecs[i].name, "E_valC",  E_valC,       64'hC000 + 64'(i));
      end
      chk(vecs[i].name, "E_valA", E_valA,       vecs[i].x_vala);
      chk(vecs[i].name, "E_valB", E_valB,       vecs[i].x_valb);
      chk(vecs[i].name, "E_dstE", 64'(E_dstE),  64'(vecs[i].x_dste));
      chk(vecs[i].name, "E_dstM", 64'(E_dstM),  64'(vecs[i].x_dstm));
      chk(vecs[i].name, "E_srcA", 64'(E_srcA),  64'(vecs[i].x_srca));
      chk(vecs[i].name, "E_srcB", 64'(E_srcB),  64'(vecs[i].x_srcb));
      if (vecs[i].rst) chk(vecs[i].name, "d_stall_post_rst", 64'(d_stall), 64'h0);
      $display("vec %0d %s: icode=%0h valA=%0h valB=%0h dstE=%0h dstM=%0h srcA=%0h srcB=%0h",
               i, vecs[i].name, E_icode, E_valA, E_valB, E_dstE, E_dstM, E_srcA, E_srcB);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
